// File: rtl/jtcps2_obj_pkg.sv
// Shared definitions for the CPS2 object drawer and pixel decoder.
package jtcps2_obj_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DRAW = 2'd2
   } obj_st_e;

   localparam logic [3:0] TRANSP = 4'hF;

   localparam int PAL_LSB   = 0;
   localparam int PAL_MSB   = 4;
   localparam int HFLIP_BIT = 5;

   localparam int BUF_PIX_W  = 4;
   localparam int BUF_PAL_W  = 5;
   localparam int BUF_PRIO_W = 3;

   // Line-buffer word is {prio, pal, pix}
   function automatic logic [BUF_PRIO_W+BUF_PAL_W+BUF_PIX_W-1:0] pack_buf(
      input logic [BUF_PRIO_W-1:0] prio,
      input logic [BUF_PAL_W-1:0]  pal,
      input logic [BUF_PIX_W-1:0]  pix
   );
      return {prio, pal, pix};
   endfunction

endpackage

// File: rtl/jtcps2_obj_pxl.sv
// Combinational 4bpp planar pixel decoder: colour of pixel j and its x offset
// within the 16-pixel tile row, honouring horizontal flip.
module jtcps2_obj_pxl (
   input  logic [31:0] data,
   input  logic [2:0]  j,
   input  logic        half,
   input  logic        hflip,
   output logic [3:0]  colour,
   output logic [3:0]  xoff
);

   logic [2:0] bsel;

   // bit (8*k + 7 - j) of each plane byte
   assign bsel   = ~j;
   assign colour = {data[{2'b11, bsel}], data[{2'b10, bsel}],
                    data[{2'b01, bsel}], data[{2'b00, bsel}]};
   assign xoff   = {half, j} ^ {4{hflip}};

endmodule

// File: rtl/jtcps2_obj_draw.sv
// CPS2 object tile drawer: fetches a 16-pixel row as two ROM halves and writes
// opaque pixels to the line buffer. Build option: JTCPS2_OBJ_SKIPBLANK_EN.
module jtcps2_obj_draw
   import jtcps2_obj_pkg::*;
#(
   parameter int AW = 23,
   parameter int BW = 12
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          line,
   input  logic          dr_start,
   output logic          dr_idle,
   input  logic [15:0]   dr_code,
   input  logic [15:0]   dr_attr,
   input  logic [8:0]    dr_hpos,
   input  logic [2:0]    dr_prio,
   input  logic [1:0]    dr_bank,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   input  logic          rom_ok,
   input  logic [31:0]   rom_data,
   output logic [9:0]    buf_addr,
   output logic [BW-1:0] buf_data,
   output logic          buf_wr
);

   obj_st_e       st, st_nxt;
   logic          half, half_nxt;
   logic [2:0]    j, j_nxt;
   logic [31:0]   data, data_nxt;
   logic          first, first_nxt;
   logic          cs_nxt, latch;
   logic [AW-1:0] rom_addr_nxt;

   logic [15:0]   code_l;
   logic [3:0]    vsub_l;
   logic [5:0]    attr_l;
   logic [8:0]    hpos_l;
   logic [2:0]    prio_l;
   logic [1:0]    bank_l;
   logic          line_l;

   logic [3:0]    colour, xoff;
   logic          unused_attr;

   assign unused_attr = ^{dr_attr[15:12], dr_attr[7:6]};

   always_comb begin
      st_nxt    = st;
      half_nxt  = half;
      j_nxt     = j;
      data_nxt  = data;
      cs_nxt    = rom_cs;
      first_nxt = 1'b0;
      latch     = 1'b0;
      case (st)
         ST_IDLE: if (dr_start) begin
            latch     = 1'b1;
            half_nxt  = 1'b0;
            cs_nxt    = 1'b1;
            first_nxt = 1'b1;
            st_nxt    = ST_REQ;
         end
         // first REQ cycle ignores rom_ok, which may still belong to the last request
         ST_REQ: if (!first && rom_ok) begin
            data_nxt = rom_data;
            cs_nxt   = 1'b0;
            j_nxt    = 3'd0;
            st_nxt   = ST_DRAW;
`ifdef JTCPS2_OBJ_SKIPBLANK_EN
            if (rom_data == 32'hFFFF_FFFF) begin
               if (!half) begin
                  half_nxt  = 1'b1;
                  cs_nxt    = 1'b1;
                  first_nxt = 1'b1;
                  st_nxt    = ST_REQ;
               end else begin
                  st_nxt = ST_IDLE;
               end
            end
`endif
         end
         ST_DRAW: begin
            j_nxt = j + 3'd1;
            if (j == 3'd7) begin
               if (!half) begin
                  half_nxt  = 1'b1;
                  cs_nxt    = 1'b1;
                  first_nxt = 1'b1;
                  st_nxt    = ST_REQ;
               end else begin
                  st_nxt = ST_IDLE;
               end
            end
         end
         default: st_nxt = ST_IDLE;
      endcase
      rom_addr_nxt = latch ? AW'({dr_bank, dr_code, dr_attr[11:8], 1'b0})
                           : AW'({bank_l, code_l, vsub_l, half_nxt});
   end

   // decode from next-state values so buf_* line up with the DRAW cycle itself
   jtcps2_obj_pxl u_pxl (
      .data   (data_nxt),
      .j      (j_nxt),
      .half   (half_nxt),
      .hflip  (attr_l[HFLIP_BIT]),
      .colour (colour),
      .xoff   (xoff)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= ST_IDLE;
         half     <= 1'b0;
         j        <= 3'd0;
         data     <= 32'd0;
         first    <= 1'b0;
         rom_cs   <= 1'b0;
         rom_addr <= '0;
         dr_idle  <= 1'b1;
         code_l   <= 16'd0;
         vsub_l   <= 4'd0;
         attr_l   <= 6'd0;
         hpos_l   <= 9'd0;
         prio_l   <= 3'd0;
         bank_l   <= 2'd0;
         line_l   <= 1'b0;
         buf_wr   <= 1'b0;
         buf_addr <= 10'd0;
         buf_data <= '0;
      end else begin
         st       <= st_nxt;
         half     <= half_nxt;
         j        <= j_nxt;
         data     <= data_nxt;
         first    <= first_nxt;
         rom_cs   <= cs_nxt;
         rom_addr <= rom_addr_nxt;
         dr_idle  <= (st_nxt == ST_IDLE);
         if (latch) begin
            code_l <= dr_code;
            vsub_l <= dr_attr[11:8];
            attr_l <= dr_attr[5:0];
            hpos_l <= dr_hpos;
            prio_l <= dr_prio;
            bank_l <= dr_bank;
            line_l <= line;
         end
         buf_wr <= (st_nxt == ST_DRAW) && (colour != TRANSP);
         if (st_nxt == ST_DRAW) begin
            buf_addr <= {line_l, hpos_l + {5'd0, xoff}};
            buf_data <= pack_buf(prio_l, attr_l[PAL_MSB:PAL_LSB], colour);
         end
      end
   end

endmodule

// File: tb/tb_jtcps2_obj_draw.sv
// Directed self-checking bench for the CPS2 object tile drawer.
module tb_jtcps2_obj_draw;

   logic        rst, clk, line, dr_start, dr_idle;
   logic [15:0] dr_code, dr_attr;
   logic [8:0]  dr_hpos;
   logic [2:0]  dr_prio;
   logic [1:0]  dr_bank;
   logic [22:0] rom_addr;
   logic        rom_cs, rom_ok;
   logic [31:0] rom_data;
   logic [9:0]  buf_addr;
   logic [11:0] buf_data;
   logic        buf_wr;

   logic [31:0] d0, d1;
   logic        ok_auto, ok_man;

   int checks   = 0;
   int failures = 0;

   logic [9:0]  wa[$];
   logic [11:0] wd[$];
   logic [22:0] ra[$];
   int          idle_k;
   int          exp_idle_blank;

   assign rom_data = rom_addr[0] ? d1 : d0;
   assign rom_ok   = ok_auto ? rom_cs : ok_man;

   jtcps2_obj_draw dut (
      .rst      (rst),
      .clk      (clk),
      .line     (line),
      .dr_start (dr_start),
      .dr_idle  (dr_idle),
      .dr_code  (dr_code),
      .dr_attr  (dr_attr),
      .dr_hpos  (dr_hpos),
      .dr_prio  (dr_prio),
      .dr_bank  (dr_bank),
      .rom_addr (rom_addr),
      .rom_cs   (rom_cs),
      .rom_ok   (rom_ok),
      .rom_data (rom_data),
      .buf_addr (buf_addr),
      .buf_data (buf_data),
      .buf_wr   (buf_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_obj(input logic [15:0] code, input logic [15:0] attr,
                          input logic [8:0] hpos, input logic [2:0] prio,
                          input logic [1:0] bank, input logic ln);
      dr_code = code;
      dr_attr = attr;
      dr_hpos = hpos;
      dr_prio = prio;
      dr_bank = bank;
      line    = ln;
   endtask

   // Starts a tile (dr_start held for 'hold' clocks) and records ROM requests
   // and line-buffer writes until dr_idle returns, bounded to 60 clocks.
   task automatic run_tile(input int hold);
      logic        prev_cs;
      logic [22:0] prev_addr;
      wa.delete();
      wd.delete();
      ra.delete();
      idle_k    = 0;
      prev_cs   = rom_cs;
      prev_addr = rom_addr;
      dr_start  = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == hold) begin
            dr_start = 1'b0;
            line     = ~line;
         end
         if (rom_cs && (!prev_cs || rom_addr != prev_addr)) ra.push_back(rom_addr);
         prev_cs   = rom_cs;
         prev_addr = rom_addr;
         if (buf_wr) begin
            wa.push_back(buf_addr);
            wd.push_back(buf_data);
         end
         if (dr_idle && k > 1) begin
            idle_k = k;
            break;
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      dr_start = 1'b0;
      ok_auto  = 1'b1;
      ok_man   = 1'b0;
      d0       = 32'd0;
      d1       = 32'd0;
      set_obj(16'd0, 16'd0, 9'd0, 3'd0, 2'd0, 1'b0);
`ifdef JTCPS2_OBJ_SKIPBLANK_EN
      exp_idle_blank = 13;
`else
      exp_idle_blank = 21;
`endif

      tick();
      tick();
      check("rst_dr_idle",   dr_idle,  1);
      check("rst_rom_cs",    rom_cs,   0);
      check("rst_rom_addr",  rom_addr, 0);
      check("rst_buf_wr",    buf_wr,   0);
      check("rst_buf_addr",  buf_addr, 0);
      check("rst_buf_data",  buf_data, 0);
      rst = 1'b0;
      tick();

      // basic draw, line toggled mid-tile
      d0 = 32'h0F0F_0F0F;
      d1 = 32'h0F0F_0F0F;
      set_obj(16'h0123, 16'h0503, 9'd100, 3'd2, 2'd1, 1'b1);
      run_tile(1);
      check("basic_nreq",   ra.size(), 2);
      check("basic_addr0",  ra[0], 23'h20246A);
      check("basic_addr1",  ra[1], 23'h20246B);
      check("basic_nwr",    wa.size(), 8);
      check("basic_wa0",    wa[0], 10'h264);
      check("basic_wa3",    wa[3], 10'h267);
      check("basic_wa4",    wa[4], 10'h26C);
      check("basic_wa7",    wa[7], 10'h26F);
      check("basic_wd0",    wd[0], 12'h430);
      check("basic_idle",   idle_k, 21);

      // hflip, all pixels opaque
      d0 = 32'h0000_0000;
      d1 = 32'h0000_0000;
      set_obj(16'h0123, 16'h0523, 9'd100, 3'd5, 2'd1, 1'b0);
      run_tile(1);
      check("hflip_nwr",   wa.size(), 16);
      check("hflip_wa0",   wa[0],  10'h073);
      check("hflip_wa7",   wa[7],  10'h06C);
      check("hflip_wa8",   wa[8],  10'h06B);
      check("hflip_wa15",  wa[15], 10'h064);
      check("hflip_wd0",   wd[0],  12'hA30);
      check("hflip_idle",  idle_k, 21);

      // blank first half, planar colour decode on second half
      d0 = 32'hFFFF_FFFF;
      d1 = 32'h8040_2010;
      set_obj(16'hABCD, 16'h0F1F, 9'd200, 3'd7, 2'd2, 1'b1);
      run_tile(1);
      check("blank_nreq",  ra.size(), 2);
      check("blank_addr0", ra[0], 23'h5579BE);
      check("blank_addr1", ra[1], 23'h5579BF);
      check("blank_nwr",   wa.size(), 8);
      check("blank_wa0",   wa[0], 10'h2D0);
      check("blank_wd0",   wd[0], 12'hFF8);
      check("blank_wd1",   wd[1], 12'hFF4);
      check("blank_wd3",   wd[3], 12'hFF1);
      check("blank_wd4",   wd[4], 12'hFF0);
      check("blank_idle",  idle_k, exp_idle_blank);

      // x wrap at 512, dr_start held two clocks
      d0 = 32'h0000_0000;
      d1 = 32'h0000_0000;
      set_obj(16'h0000, 16'h0000, 9'd508, 3'd0, 2'd0, 1'b0);
      run_tile(2);
      check("wrap_nreq",  ra.size(), 2);
      check("wrap_addr1", ra[1], 23'h000001);
      check("wrap_nwr",   wa.size(), 16);
      check("wrap_wa0",   wa[0],  10'h1FC);
      check("wrap_wa3",   wa[3],  10'h1FF);
      check("wrap_wa4",   wa[4],  10'h000);
      check("wrap_wa15",  wa[15], 10'h00B);
      check("wrap_idle",  idle_k, 21);

      // ROM wait states, stale ok, then reset mid-DRAW
      ok_auto = 1'b0;
      ok_man  = 1'b0;
      set_obj(16'h0001, 16'h0100, 9'd0, 3'd0, 2'd0, 1'b0);
      dr_start = 1'b1;
      tick();
      dr_start = 1'b0;
      ok_man   = 1'b1;
      tick();
      check("stale_ok_cs", rom_cs, 1);
      ok_man = 1'b0;
      for (int w = 0; w < 5; w++) begin
         tick();
         check("wait_cs",   rom_cs,   1);
         check("wait_addr", rom_addr, 23'h000022);
      end
      ok_man = 1'b1;
      tick();
      ok_man = 1'b0;
      check("wait_cs_drop", rom_cs, 0);
      check("wait_wr_j0",   buf_wr, 1);
      tick();
      tick();
      tick();
      check("wait_addr_j3", buf_addr, 10'h003);
      rst = 1'b1;
      #1;
      check("rstmid_buf_wr",  buf_wr,  0);
      check("rstmid_rom_cs",  rom_cs,  0);
      check("rstmid_dr_idle", dr_idle, 1);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_wr", buf_wr, 0);

      ok_auto = 1'b1;
      d0 = 32'h0F0F_0F0F;
      d1 = 32'h0F0F_0F0F;
      set_obj(16'h0123, 16'h0503, 9'd100, 3'd2, 2'd1, 1'b1);
      run_tile(1);
      check("after_rst_nwr",  wa.size(), 8);
      check("after_rst_wa0",  wa[0], 10'h264);
      check("after_rst_idle", idle_k, 21);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
